// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel-request / sync / RGB bundle between the timing master and the pixel generator side
interface vga_timing_if;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        hsync;
    logic        vsync;
    logic        rgb_valid;
    logic [15:0] rgb;
    modport master (input pix_data, output pix_x, pix_y, hsync, vsync, rgb_valid, rgb);
    modport slave (output pix_data, input pix_x, pix_y, hsync, vsync, rgb_valid, rgb);
endinterface

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 raster timing master; define VGA_TIMING_FRAME_CNT_EN to add frame_cnt/frame_start
module vga_timing_ctrl #(
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   H_VALID  = 640,
    parameter int   H_FRONT  = 16,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter int   V_VALID  = 480,
    parameter int   V_FRONT  = 10,
    parameter logic SYNC_POL = 1'b0
) (
    input logic vga_clk,
    input logic sys_rst_n,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [15:0] frame_cnt,
    output logic [0:0]  frame_start,
`endif
    vga_timing_if.master vga
);
    localparam logic [9:0] H_LAST = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
    localparam logic [9:0] V_LAST = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
    localparam logic [9:0] HS = 10'(H_SYNC);
    localparam logic [9:0] VS = 10'(V_SYNC);
    localparam logic [9:0] HA = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] HE = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] VA = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] VE = 10'(V_SYNC + V_BACK + V_VALID);
    logic [9:0] cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;
    logic h_end, frame_end, v_win, h_win, h_req;
    always_comb begin
        h_end = cnt_h_q == H_LAST;
        frame_end = h_end && cnt_v_q == V_LAST;
        cnt_h_d = h_end ? 10'd0 : cnt_h_q + 10'd1;
        cnt_v_d = frame_end ? 10'd0 : cnt_v_q + 10'(h_end);
        v_win = cnt_v_q >= VA && cnt_v_q < VE;
        h_win = cnt_h_q >= HA && cnt_h_q < HE;
        // requests lead the display window by one clock to absorb the generator's register
        h_req = cnt_h_q >= HA - 10'd1 && cnt_h_q < HE - 10'd1;
        vga.hsync = cnt_h_q < HS ? SYNC_POL : ~SYNC_POL;
        vga.vsync = cnt_v_q < VS ? SYNC_POL : ~SYNC_POL;
        vga.rgb_valid = h_win && v_win;
        vga.pix_x = h_req && v_win ? cnt_h_q - (HA - 10'd1) : 10'h3FF;
        vga.pix_y = h_req && v_win ? cnt_v_q - VA : 10'h3FF;
        vga.rgb = h_win && v_win ? vga.pix_data : 16'h0000;
    end
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_q <= 10'd0;
            cnt_v_q <= 10'd0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    always_comb frame_cnt_d = frame_cnt_q + 16'(frame_end);
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) frame_cnt_q <= 16'd0;
        else frame_cnt_q <= frame_cnt_d;
    end
    assign frame_cnt = frame_cnt_q;
    assign frame_start = sys_rst_n && cnt_h_q == 10'd0 && cnt_v_q == 10'd0;
`endif
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: full-size instance for line-level timing, shrunken instance for frame-level timing
module tb_vga_timing_ctrl;
    logic vga_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic rst_s_n = 1'b0;
    always #20 vga_clk = ~vga_clk;
    vga_timing_if vif ();
    vga_timing_if sif ();
    logic [15:0] gen_q = 16'h0000;
    logic [15:0] ovr = 16'h0000;
    logic ovr_en = 1'b0;
    int n_chk = 0;
    int n_bad = 0;
    int pos = 0;
    assign vif.pix_data = ovr_en ? ovr : gen_q;
    assign sif.pix_data = 16'h1234;
    always @(posedge vga_clk)
        gen_q <= (vif.pix_x == 10'h3FF || vif.pix_y == 10'h3FF) ? 16'h0000 : ({vif.pix_y[5:0], vif.pix_x} ^ 16'hA5C3);
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc_d, fc_s;
    logic [0:0]  fs_d, fs_s;
`endif
    vga_timing_ctrl dut (
        .vga_clk(vga_clk),
        .sys_rst_n(sys_rst_n),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(fc_d),
        .frame_start(fs_d),
`endif
        .vga(vif)
    );
    vga_timing_ctrl #(
        .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(3), .V_VALID(5), .V_FRONT(2)
    ) dut_s (
        .vga_clk(vga_clk),
        .sys_rst_n(rst_s_n),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(fc_s),
        .frame_start(fs_s),
`endif
        .vga(sif)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic goto(input int h, input int v);
        while (pos < v * 800 + h) begin
            @(negedge vga_clk);
            pos++;
        end
        #1;
    endtask

    task automatic measure_line(input string p);
        int lo, rise;
        logic hs_last;
        lo = 0;
        rise = -1;
        hs_last = 1'b0;
        for (int i = 0; i < 800; i++) begin
            #1;
            if (!vif.hsync) lo++;
            else if (rise < 0) rise = i;
            hs_last = vif.hsync;
            @(negedge vga_clk);
        end
        #1;
        pos += 800;
        chk({p, "_hs_lo"}, 32'(lo), 32'd96);
        chk({p, "_hs_rise"}, 32'(rise), 32'd96);
        chk({p, "_hs_799"}, 32'(hs_last), 32'd1);
        chk({p, "_hs_800"}, 32'(vif.hsync), 32'd0);
    endtask

    initial begin
        int vs_lo0, vs_lo1, vs_rise, valid0, row5;
        logic [11:0] rowmask;
        ovr_en = 1'b1;
        ovr = 16'hFFFF;
        repeat (3) @(negedge vga_clk);
        #1;
        chk("rst_hsync", 32'(vif.hsync), 32'd0);
        chk("rst_vsync", 32'(vif.vsync), 32'd0);
        chk("rst_valid", 32'(vif.rgb_valid), 32'd0);
        chk("rst_rgb", 32'(vif.rgb), 32'd0);
        chk("rst_pix_x", 32'(vif.pix_x), 32'h3FF);
        chk("rst_pix_y", 32'(vif.pix_y), 32'h3FF);
        ovr_en = 1'b0;
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        pos = 0;
        measure_line("l0");
        goto(300, 34);
        chk("v34_pix_y", 32'(vif.pix_y), 32'h3FF);
        chk("v34_valid", 32'(vif.rgb_valid), 32'd0);
        goto(143, 35);
        chk("h143_pix_x", 32'(vif.pix_x), 32'd0);
        chk("h143_pix_y", 32'(vif.pix_y), 32'd0);
        chk("h143_valid", 32'(vif.rgb_valid), 32'd0);
        ovr_en = 1'b1;
        #1;
        chk("h143_rgb_gate", 32'(vif.rgb), 32'd0);
        ovr_en = 1'b0;
        goto(144, 35);
        chk("h144_valid", 32'(vif.rgb_valid), 32'd1);
        chk("h144_rgb", 32'(vif.rgb), 32'hA5C3);
        goto(145, 35);
        chk("h145_pix_x", 32'(vif.pix_x), 32'd2);
        chk("h145_rgb", 32'(vif.rgb), 32'hA5C2);
        goto(782, 35);
        chk("h782_pix_x", 32'(vif.pix_x), 32'd639);
        chk("h782_rgb", 32'(vif.rgb), 32'hA7BD);
        goto(783, 35);
        chk("h783_pix_x", 32'(vif.pix_x), 32'h3FF);
        chk("h783_valid", 32'(vif.rgb_valid), 32'd1);
        chk("h783_rgb", 32'(vif.rgb), 32'hA7BC);
        goto(784, 35);
        chk("h784_valid", 32'(vif.rgb_valid), 32'd0);
        ovr_en = 1'b1;
        #1;
        chk("h784_rgb_gate", 32'(vif.rgb), 32'd0);
        ovr_en = 1'b0;
        goto(144, 36);
        chk("v36_pix_y", 32'(vif.pix_y), 32'd1);
        chk("v36_rgb", 32'(vif.rgb), 32'hA1C3);
        goto(400, 36);
        chk("mid_pix_x", 32'(vif.pix_x), 32'd257);
        chk("mid_valid", 32'(vif.rgb_valid), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_hsync", 32'(vif.hsync), 32'd0);
        chk("mid_rst_vsync", 32'(vif.vsync), 32'd0);
        chk("mid_rst_valid", 32'(vif.rgb_valid), 32'd0);
        chk("mid_rst_rgb", 32'(vif.rgb), 32'd0);
        chk("mid_rst_pix_x", 32'(vif.pix_x), 32'h3FF);
        chk("mid_rst_pix_y", 32'(vif.pix_y), 32'h3FF);
        repeat (2) @(negedge vga_clk);
        sys_rst_n = 1'b1;
        pos = 0;
        measure_line("post_rst");
        goto(799, 1);
        chk("v1_end_vsync", 32'(vif.vsync), 32'd0);
        goto(0, 2);
        chk("v2_vsync", 32'(vif.vsync), 32'd1);

        vs_lo0 = 0;
        vs_lo1 = 0;
        vs_rise = -1;
        valid0 = 0;
        row5 = 0;
        rowmask = '0;
        @(negedge vga_clk);
        rst_s_n = 1'b1;
        for (int k = 0; k < 818; k++) begin
            #1;
            if (k < 204) begin
                if (!sif.vsync) vs_lo0++;
                else if (vs_rise < 0) vs_rise = k;
                if (sif.rgb_valid) begin
                    valid0++;
                    rowmask[k / 17] = 1'b1;
                    if (k / 17 == 5) row5++;
                end
            end else if (k < 408 && !sif.vsync) vs_lo1++;
            if (k == 98) chk("s_last_pix_x", 32'(sif.pix_x), 32'd7);
            if (k == 99) chk("s_past_pix_x", 32'(sif.pix_x), 32'h3FF);
            if (k == 159) chk("s_last_pix_y", 32'(sif.pix_y), 32'd4);
            if (k == 159) chk("s_last_row_x", 32'(sif.pix_x), 32'd0);
            if (k == 176) chk("s_past_pix_y", 32'(sif.pix_y), 32'h3FF);
            if (k == 203) chk("s_wrap_pre_vs", 32'(sif.vsync), 32'd1);
            if (k == 204) chk("s_wrap_vs", 32'(sif.vsync), 32'd0);
            if (k == 204) chk("s_wrap_hs", 32'(sif.hsync), 32'd0);
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (k == 0 || k == 204 || k == 408) chk("s_fstart_hi", 32'(fs_s), 32'd1);
            if (k == 1 || k == 203 || k == 205) chk("s_fstart_lo", 32'(fs_s), 32'd0);
            if (k == 612) chk("s_fcnt3", 32'(fc_s), 32'd3);
            if (k == 700) force dut_s.frame_cnt_q = 16'hFFFF;
            if (k == 701) chk("s_fcnt_forced", 32'(fc_s), 32'hFFFF);
            if (k == 815) chk("s_fcnt_hold", 32'(fc_s), 32'hFFFF);
            if (k == 816) chk("s_fcnt_wrap", 32'(fc_s), 32'd0);
`endif
            @(negedge vga_clk);
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (k == 700) release dut_s.frame_cnt_q;
`endif
        end
        chk("s_vs_lo0", 32'(vs_lo0), 32'd34);
        chk("s_vs_lo1", 32'(vs_lo1), 32'd34);
        chk("s_vs_rise", 32'(vs_rise), 32'd34);
        chk("s_valid_frame", 32'(valid0), 32'd40);
        chk("s_valid_row5", 32'(row5), 32'd8);
        chk("s_valid_rows", 32'(rowmask), 32'h3E0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
